// File: rtl/int_issue_queue_pkg.sv
// Shared types and constants for the integer issue queue.
package int_issue_queue_pkg;

  localparam int IQ_DEPTH  = 16;
  localparam int IQ_ADDR_W = 5;
  localparam int IQ_PRF_W  = 6;
  localparam int IQ_ROB_W  = 6;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_LS  = 2'd2;
  localparam logic [1:0] FU_BAD = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [1:0]          fu;
    logic [IQ_PRF_W-1:0] prd;
    logic [IQ_PRF_W-1:0] prs1;
    logic [IQ_PRF_W-1:0] prs2;
    logic                rdy1;
    logic                rdy2;
    logic [IQ_ROB_W-1:0] rob_id;
  } iq_entry_t;

  // Number of distinct entries freed by this cycle's grants; a grant that
  // repeats an earlier grant's address is not counted twice.
  function automatic logic [2:0] grant_count(input logic [3:0] g,
                                             input logic [3:0] a0,
                                             input logic [3:0] a1,
                                             input logic [3:0] a2,
                                             input logic [3:0] a3);
    logic [2:0] n;
    n = {2'b00, g[0]};
    if (g[1] && !(g[0] && a1 == a0)) n = n + 3'd1;
    if (g[2] && !(g[0] && a2 == a0) && !(g[1] && a2 == a1)) n = n + 3'd1;
    if (g[3] && !(g[0] && a3 == a0) && !(g[1] && a3 == a1) &&
        !(g[2] && a3 == a2)) n = n + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Dispatch handshake from rename into the integer issue queue.
interface int_issue_queue_if
  import int_issue_queue_pkg::*;
#(
  parameter int PRF_WIDTH = IQ_PRF_W,
  parameter int ROB_WIDTH = IQ_ROB_W
);
  logic                 disp_valid;
  logic                 disp_ready;
  logic [1:0]           disp_fu;
  logic [PRF_WIDTH-1:0] disp_prd;
  logic [PRF_WIDTH-1:0] disp_prs1;
  logic [PRF_WIDTH-1:0] disp_prs2;
  logic                 disp_prs1_rdy;
  logic                 disp_prs2_rdy;
  logic [ROB_WIDTH-1:0] disp_rob_id;

  modport master (
    output disp_valid, disp_fu, disp_prd, disp_prs1, disp_prs2,
           disp_prs1_rdy, disp_prs2_rdy, disp_rob_id,
    input  disp_ready
  );

  modport slave (
    input  disp_valid, disp_fu, disp_prd, disp_prs1, disp_prs2,
           disp_prs1_rdy, disp_prs2_rdy, disp_rob_id,
    output disp_ready
  );
endinterface

// File: rtl/int_issue_queue_free_pick.sv
// Lowest-set-bit priority encoder used to choose the dispatch slot.
module iq_free_pick (
  input  logic [15:0] free_vec,
  output logic [15:0] pick_oh,
  output logic [3:0]  pick_idx,
  output logic        any_free
);

  // Scan from the top down so the lowest free index is the last one kept.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    any_free = |free_vec;
    for (int i = 15; i >= 0; i--) begin
      if (free_vec[i]) begin
        pick_oh     = '0;
        pick_oh[i]  = 1'b1;
        pick_idx    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// 16-entry unified integer issue queue: holds renamed ops, tracks source
// readiness and raises per-FU request vectors for the select stage.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int PRF_WIDTH = IQ_PRF_W,
  parameter int IQ_DEPTH  = 16,
  parameter int ROB_WIDTH = IQ_ROB_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  int_issue_queue_if.slave              disp,
  input  logic [15:0]                   wk_prs1_rdy,
  input  logic [15:0]                   wk_prs2_rdy,
  input  logic                          grant_alu0,
  input  logic                          grant_alu1,
  input  logic                          grant_mul,
  input  logic                          grant_ls,
  input  logic [4:0]                    addr_alu0,
  input  logic [4:0]                    addr_alu1,
  input  logic [4:0]                    addr_mul,
  input  logic [4:0]                    addr_ls,
  output logic [16*PRF_WIDTH-1:0]       ciq_prd,
  output logic [16*PRF_WIDTH-1:0]       ciq_prs1,
  output logic [16*PRF_WIDTH-1:0]       ciq_prs2,
  output logic [16*ROB_WIDTH-1:0]       ciq_rob_id,
  output logic [15:0]                   req_alu,
  output logic [15:0]                   req_mul,
  output logic [15:0]                   req_ls,
  output logic [4:0]                    iq_count,
  output logic                          iq_full,
  output logic                          iq_empty
);

  iq_entry_t   ent [16];
  iq_entry_t   new_entry;
  logic [15:0] valid_vec;
  logic [15:0] gnt_clr;
  logic [15:0] pick_oh;
  logic [3:0]  pick_idx;
  logic        any_free;
  logic        accept;
  logic        bypass1;
  logic        bypass2;
  logic [2:0]  n_grants;
  logic [3:0]  grant_vec;
  logic [4:0]  count_reg;
  logic [4:0]  count_next;

  assign grant_vec = {grant_ls, grant_mul, grant_alu1, grant_alu0};
  assign n_grants  = grant_count(grant_vec, addr_alu0[3:0], addr_alu1[3:0],
                                 addr_mul[3:0], addr_ls[3:0]);

  assign iq_count        = count_reg;
  assign iq_full         = (count_reg == 5'd16);
  assign iq_empty        = (count_reg == 5'd0);
  assign disp.disp_ready = ~iq_full;
  assign accept          = disp.disp_valid & disp.disp_ready & ~flush;

  // Slot choice only looks at entries invalid at the start of the cycle,
  // so a slot freed by a grant this cycle is not reused until next cycle.
  iq_free_pick u_free_pick (
    .free_vec (~valid_vec),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any_free (any_free)
  );

  // Decode grants into per-entry free strobes.
  always_comb begin
    gnt_clr = '0;
    if (grant_alu0) gnt_clr[addr_alu0[3:0]] = 1'b1;
    if (grant_alu1) gnt_clr[addr_alu1[3:0]] = 1'b1;
    if (grant_mul)  gnt_clr[addr_mul[3:0]]  = 1'b1;
    if (grant_ls)   gnt_clr[addr_ls[3:0]]   = 1'b1;
  end

  // Same-cycle wake-up of the incoming op by any producer granted now.
  always_comb begin
    bypass1 = (grant_alu0 && ent[addr_alu0[3:0]].prd == disp.disp_prs1) ||
              (grant_alu1 && ent[addr_alu1[3:0]].prd == disp.disp_prs1) ||
              (grant_mul  && ent[addr_mul[3:0]].prd  == disp.disp_prs1) ||
              (grant_ls   && ent[addr_ls[3:0]].prd   == disp.disp_prs1);
    bypass2 = (grant_alu0 && ent[addr_alu0[3:0]].prd == disp.disp_prs2) ||
              (grant_alu1 && ent[addr_alu1[3:0]].prd == disp.disp_prs2) ||
              (grant_mul  && ent[addr_mul[3:0]].prd  == disp.disp_prs2) ||
              (grant_ls   && ent[addr_ls[3:0]].prd   == disp.disp_prs2);
  end

  // Build the entry written on dispatch; an illegal FU class is dropped.
  always_comb begin
    new_entry        = '0;
    new_entry.valid  = (disp.disp_fu != FU_BAD);
    new_entry.fu     = (disp.disp_fu == FU_BAD) ? FU_ALU : disp.disp_fu;
    new_entry.prd    = disp.disp_prd;
    new_entry.prs1   = disp.disp_prs1;
    new_entry.prs2   = disp.disp_prs2;
    new_entry.rdy1   = disp.disp_prs1_rdy | bypass1;
    new_entry.rdy2   = disp.disp_prs2_rdy | bypass2;
    new_entry.rob_id = disp.disp_rob_id;
  end

  // Occupancy: dispatch adds one, each distinct grant removes one.
  always_comb begin
    count_next = count_reg + {4'd0, accept} - {2'd0, n_grants};
    if (flush) count_next = '0;
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) count_reg <= '0;
    else     count_reg <= count_next;
  end

  for (genvar gi = 0; gi < 16; gi++) begin : gen_entry
    iq_entry_t entry_reg;

    // Per-entry state: flush beats dispatch, dispatch beats grant/wake-up.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (flush) begin
        entry_reg.valid <= 1'b0;
        entry_reg.rdy1  <= 1'b0;
        entry_reg.rdy2  <= 1'b0;
      end else if (accept && pick_oh[gi]) begin
        entry_reg <= new_entry;
      end else if (gnt_clr[gi]) begin
        entry_reg.valid <= 1'b0;
        entry_reg.rdy1  <= 1'b0;
        entry_reg.rdy2  <= 1'b0;
      end else begin
        entry_reg.rdy1 <= entry_reg.rdy1 | (wk_prs1_rdy[gi] & entry_reg.valid);
        entry_reg.rdy2 <= entry_reg.rdy2 | (wk_prs2_rdy[gi] & entry_reg.valid);
      end
    end

    assign ent[gi]       = entry_reg;
    assign valid_vec[gi] = entry_reg.valid;
    assign ciq_prd[gi*PRF_WIDTH +: PRF_WIDTH]    = entry_reg.prd;
    assign ciq_prs1[gi*PRF_WIDTH +: PRF_WIDTH]   = entry_reg.prs1;
    assign ciq_prs2[gi*PRF_WIDTH +: PRF_WIDTH]   = entry_reg.prs2;
    assign ciq_rob_id[gi*ROB_WIDTH +: ROB_WIDTH] = entry_reg.rob_id;
    assign req_alu[gi] = entry_reg.valid & entry_reg.rdy1 & entry_reg.rdy2 &
                         (entry_reg.fu == FU_ALU);
    assign req_mul[gi] = entry_reg.valid & entry_reg.rdy1 & entry_reg.rdy2 &
                         (entry_reg.fu == FU_MUL);
    assign req_ls[gi]  = entry_reg.valid & entry_reg.rdy1 & entry_reg.rdy2 &
                         (entry_reg.fu == FU_LS);
  end

  // Protocol checks on grants and dispatch; no effect on the logic above.
  always @(posedge clk) begin
    if (!rst && !flush) begin
      if (grant_alu0) assert (!addr_alu0[4] && valid_vec[addr_alu0[3:0]]);
      if (grant_alu1) assert (!addr_alu1[4] && valid_vec[addr_alu1[3:0]]);
      if (grant_mul)  assert (!addr_mul[4]  && valid_vec[addr_mul[3:0]]);
      if (grant_ls)   assert (!addr_ls[4]   && valid_vec[addr_ls[3:0]]);
      assert ({1'b0, n_grants} == 4'(grant_alu0) + 4'(grant_alu1) +
                                  4'(grant_mul) + 4'(grant_ls));
      if (accept) begin
        assert (disp.disp_fu != FU_BAD);
        assert (any_free && pick_oh[pick_idx]);
      end
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue with hand-computed expectations.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] wk_prs1_rdy, wk_prs2_rdy;
  logic        grant_alu0, grant_alu1, grant_mul, grant_ls;
  logic [4:0]  addr_alu0, addr_alu1, addr_mul, addr_ls;
  logic [95:0] ciq_prd, ciq_prs1, ciq_prs2, ciq_rob_id;
  logic [15:0] req_alu, req_mul, req_ls;
  logic [4:0]  iq_count;
  logic        iq_full, iq_empty;

  int checks   = 0;
  int failures = 0;

  int_issue_queue_if ifc ();

  int_issue_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .disp        (ifc),
    .wk_prs1_rdy (wk_prs1_rdy),
    .wk_prs2_rdy (wk_prs2_rdy),
    .grant_alu0  (grant_alu0),
    .grant_alu1  (grant_alu1),
    .grant_mul   (grant_mul),
    .grant_ls    (grant_ls),
    .addr_alu0   (addr_alu0),
    .addr_alu1   (addr_alu1),
    .addr_mul    (addr_mul),
    .addr_ls     (addr_ls),
    .ciq_prd     (ciq_prd),
    .ciq_prs1    (ciq_prs1),
    .ciq_prs2    (ciq_prs2),
    .ciq_rob_id  (ciq_rob_id),
    .req_alu     (req_alu),
    .req_mul     (req_mul),
    .req_ls      (req_ls),
    .iq_count    (iq_count),
    .iq_full     (iq_full),
    .iq_empty    (iq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    wk_prs1_rdy = '0;
    wk_prs2_rdy = '0;
    grant_alu0  = 1'b0; grant_alu1 = 1'b0; grant_mul = 1'b0; grant_ls = 1'b0;
    addr_alu0   = '0;   addr_alu1  = '0;   addr_mul  = '0;   addr_ls  = '0;
    ifc.disp_valid = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] fu, input logic [5:0] prd,
                        input logic [5:0] prs1, input logic [5:0] prs2,
                        input logic r1, input logic r2);
    ifc.disp_valid    = 1'b1;
    ifc.disp_fu       = fu;
    ifc.disp_prd      = prd;
    ifc.disp_prs1     = prs1;
    ifc.disp_prs2     = prs2;
    ifc.disp_prs1_rdy = r1;
    ifc.disp_prs2_rdy = r2;
    ifc.disp_rob_id   = prd;
  endtask

  task automatic dispatch(input logic [1:0] fu, input logic [5:0] prd,
                          input logic [5:0] prs1, input logic [5:0] prs2,
                          input logic r1, input logic r2);
    set_op(fu, prd, prs1, prs2, r1, r2);
    tick();
    ifc.disp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    // Reset while an op is being offered: it must be discarded.
    set_op(FU_ALU, 6'd12, 6'd0, 6'd0, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.disp_valid = 1'b0;
    chk("rst_count", 32'(iq_count), 32'd0);
    chk("rst_empty", 32'(iq_empty), 32'd1);
    chk("rst_full", 32'(iq_full), 32'd0);
    chk("rst_ready", 32'(ifc.disp_ready), 32'd1);
    chk("rst_req_alu", 32'(req_alu), 32'h0);
    chk("rst_prd0", 32'(ciq_prd[5:0]), 32'd0);

    // Three ready ALU ops fill entries 0..2.
    dispatch(FU_ALU, 6'd1, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_ALU, 6'd2, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_ALU, 6'd3, 6'd0, 6'd0, 1'b1, 1'b1);
    chk("t1_req_alu", 32'(req_alu), 32'h0007);
    chk("t1_count", 32'(iq_count), 32'd3);
    chk("t1_prd2", 32'(ciq_prd[12 +: 6]), 32'd3);

    // Back-to-back: grant producer 0 while wake-up hits consumer 1.
    do_reset();
    dispatch(FU_ALU, 6'd10, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_ALU, 6'd11, 6'd10, 6'd0, 1'b0, 1'b1);
    chk("t2_req_before", 32'(req_alu), 32'h0001);
    grant_alu0 = 1'b1; addr_alu0 = 5'd0; wk_prs1_rdy = 16'h0002;
    tick();
    idle_inputs();
    chk("t2_req_after", 32'(req_alu), 32'h0002);
    chk("t2_count", 32'(iq_count), 32'd1);

    // Same-cycle bypass into a newly dispatched op.
    do_reset();
    dispatch(FU_ALU, 6'd1, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_ALU, 6'd2, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_MUL, 6'd7, 6'd0, 6'd0, 1'b1, 1'b1);
    chk("t3_req_mul", 32'(req_mul), 32'h0004);
    grant_mul = 1'b1; addr_mul = 5'd2;
    set_op(FU_ALU, 6'd8, 6'd7, 6'd0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    chk("t3_req_alu", 32'(req_alu), 32'h000B);
    chk("t3_req_mul_after", 32'(req_mul), 32'h0000);
    chk("t3_count", 32'(iq_count), 32'd3);
    chk("t3_prd3", 32'(ciq_prd[18 +: 6]), 32'd8);

    // Fill to 16, then free entry 5 while offering a dispatch.
    do_reset();
    for (int i = 0; i < 16; i++) dispatch(FU_LS, 6'(i), 6'd0, 6'd0, 1'b1, 1'b1);
    chk("t4_full", 32'(iq_full), 32'd1);
    chk("t4_ready", 32'(ifc.disp_ready), 32'd0);
    chk("t4_count16", 32'(iq_count), 32'd16);
    chk("t4_req_ls", 32'(req_ls), 32'hFFFF);
    grant_ls = 1'b1; addr_ls = 5'd5;
    set_op(FU_LS, 6'd40, 6'd0, 6'd0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("t4_count15", 32'(iq_count), 32'd15);
    chk("t4_req_ls_hole", 32'(req_ls), 32'hFFDF);
    chk("t4_prd5_kept", 32'(ciq_prd[30 +: 6]), 32'd5);
    dispatch(FU_LS, 6'd40, 6'd0, 6'd0, 1'b1, 1'b1);
    chk("t4_count_back", 32'(iq_count), 32'd16);
    chk("t4_prd5_new", 32'(ciq_prd[30 +: 6]), 32'd40);
    chk("t4_req_ls_full", 32'(req_ls), 32'hFFFF);

    // Four grants from a count of 10, then flush with a dispatch offered.
    do_reset();
    for (int i = 0; i < 6; i++) dispatch(FU_ALU, 6'(20 + i), 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_MUL, 6'd26, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_MUL, 6'd27, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_LS, 6'd28, 6'd0, 6'd0, 1'b1, 1'b1);
    dispatch(FU_LS, 6'd29, 6'd0, 6'd0, 1'b1, 1'b1);
    chk("t5_count10", 32'(iq_count), 32'd10);
    chk("t5_req_alu", 32'(req_alu), 32'h003F);
    chk("t5_req_mul", 32'(req_mul), 32'h00C0);
    chk("t5_req_ls", 32'(req_ls), 32'h0300);
    grant_alu0 = 1'b1; addr_alu0 = 5'd0;
    grant_alu1 = 1'b1; addr_alu1 = 5'd1;
    grant_mul  = 1'b1; addr_mul  = 5'd6;
    grant_ls   = 1'b1; addr_ls   = 5'd8;
    tick();
    idle_inputs();
    chk("t5_count6", 32'(iq_count), 32'd6);
    chk("t5_req_alu_after", 32'(req_alu), 32'h003C);
    chk("t5_req_mul_after", 32'(req_mul), 32'h0080);
    chk("t5_req_ls_after", 32'(req_ls), 32'h0200);
    flush = 1'b1;
    set_op(FU_ALU, 6'd50, 6'd0, 6'd0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("t5_flush_count", 32'(iq_count), 32'd0);
    chk("t5_flush_empty", 32'(iq_empty), 32'd1);
    chk("t5_flush_reqs", 32'({req_alu, req_mul} | 32'(req_ls)), 32'h0);
    chk("t5_flush_prd0", 32'(ciq_prd[5:0]), 32'd20);

    // Wake-up on an empty queue must not create valid or ready entries.
    wk_prs1_rdy = 16'hFFFF; wk_prs2_rdy = 16'hFFFF;
    tick();
    idle_inputs();
    chk("t6_count", 32'(iq_count), 32'd0);
    chk("t6_reqs", 32'({req_alu, req_mul} | 32'(req_ls)), 32'h0);
    // A later non-ready op waits for its own wake-up.
    dispatch(FU_ALU, 6'd9, 6'd33, 6'd0, 1'b0, 1'b1);
    chk("t6_req_wait", 32'(req_alu), 32'h0000);
    wk_prs1_rdy = 16'h0001;
    tick();
    idle_inputs();
    chk("t6_req_woken", 32'(req_alu), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- 16-entry unified integer issue queue. It stores renamed micro-ops, tracks per-source ready bits, and raises per-functional-unit request vectors.
- Sits directly upstream of the wake-up stage: it drives the entry tag arrays (prd/prs1/prs2) that wake-up compares against granted destinations.
- It consumes wake-up's prs1_rdy/prs2_rdy vectors and the select stage's grants.
- Issued entries are freed; flush empties the queue.

Parameters:
- PRF_WIDTH, 6, physical register tag width
- IQ_DEPTH, 16, entry count (fixed at 16; addr ports are 5 bits)
- ROB_WIDTH, 6, ROB index width carried per entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; invalidates all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept (= !full)
- disp_fu  in  2  FU class: 0 ALU, 1 MUL, 2 LS (3 illegal)
- disp_prd  in  PRF_WIDTH  destination tag
- disp_prs1  in  PRF_WIDTH  source-1 tag
- disp_prs2  in  PRF_WIDTH  source-2 tag
- disp_prs1_rdy  in  1  source-1 ready at rename
- disp_prs2_rdy  in  1  source-2 ready at rename
- disp_rob_id  in  ROB_WIDTH  ROB index
- wk_prs1_rdy  in  16  wake-up hits per entry, source 1
- wk_prs2_rdy  in  16  wake-up hits per entry, source 2
- grant_alu0, grant_alu1, grant_mul, grant_ls  in  1 each  select grants
- addr_alu0, addr_alu1, addr_mul, addr_ls  in  5 each  granted entry index (bit 4 must be 0)
- ciq_prd, ciq_prs1, ciq_prs2  out  16*PRF_WIDTH each  entry tag arrays, entry i at [i*PRF_WIDTH +: PRF_WIDTH]
- ciq_rob_id  out  16*ROB_WIDTH  entry ROB indices
- req_alu, req_mul, req_ls  out  16 each  per-entry issue requests
- iq_count  out  5  valid entries
- iq_full  out  1  all 16 valid
- iq_empty  out  1  none valid

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all valid, rdy1, rdy2 and fu fields cleared; tag arrays and rob_id cleared to 0.
  - iq_count=0, iq_empty=1, iq_full=0, disp_ready=1 after the edge.
  - Reset mid-dispatch discards the op.
- Request (combinational from registers):
  - req_X[i] = valid[i] & rdy1[i] & rdy2[i] & (fu[i]==X).
  - ALU requests feed both alu0 and alu1 select.
- Grant handling (cycle N):
  - Each asserted grant clears valid[addr] at the edge ending N; the entry is not requestable from N+1.
  - Granted entries must be requesting; a grant to an invalid entry or two grants to one address is illegal (simulation assertion, no RTL effect).
- Wake-up:
  - At the edge ending N, rdy1[i] |= wk_prs1_rdy[i] & valid[i], and likewise for rdy2.
  - Ready bits are sticky until the entry is freed.
  - Wake-up hits on invalid entries are ignored (wake-up compares stale tags).
  - Dependent op can request in N+1 after its producer is granted in N (back-to-back issue).
- Dispatch:
  - Accepted when disp_valid & disp_ready & !flush.
  - Written at the edge into the lowest-index entry that was invalid at the start of the cycle; an entry freed by a grant in the same cycle is not reused until N+1.
  - rdy1 = disp_prs1_rdy | bypass1, where bypass1 = disp_prs1 matches ciq_prd[addr_g] for any asserted grant g (same-cycle wake-up of the new entry). rdy2 is formed the same way.
  - disp_fu==3: the op is accepted but marked fu=ALU with valid=0 (dropped); assertion fires.
- Count:
  - iq_count next = count + accepted_dispatch − number_of_asserted_grants (0..4).
  - Grant count excludes duplicate-address grants (illegal).
  - iq_full = (count==16); iq_empty = (count==0); all registered-derived.
- Flush:
  - Has priority over dispatch, grants and wake-up: all valid and ready bits clear, count=0.
  - Tag arrays hold stale values.
- Simultaneous full + grant: disp_ready stays 0 that cycle (no same-cycle reuse).

Decomposition:
- Shared package holds:
  - FU encodings FU_ALU=0, FU_MUL=1, FU_LS=2.
  - IQ_DEPTH=16 and IQ_ADDR_W=5.
  - The entry struct: valid, fu, prd, prs1, prs2, rdy1, rdy2, rob_id.
- One natural sub-module, iq_free_pick: 16-bit lowest-set-bit priority encoder returning a one-hot, an index and an any-free flag.

Test Plan:
- Reset then dispatch 3 ops with both rdy=1, fu=ALU → req_alu=16'h0007 next cycle; iq_count=3.
- Dispatch op A (prd=10) into entry 0 and op B (prs1=10, rdy1=0, prs2 rdy) into entry 1. Grant alu0 addr 0 in cycle N with wk_prs1_rdy[1]=1 → req_alu[1]=1 in N+1, valid[0]=0, count=1.
- Grant mul on entry 2 (prd=7) in the same cycle as dispatching prs1=7 with rdy1=0 → the new entry captures rdy1=1 via bypass and requests the next cycle.
- Fill 16 entries → iq_full=1, disp_ready=0. Grant entry 5 while disp_valid → nothing written that cycle. The next dispatch lands in entry 5 and count returns to 16.
- Four grants in one cycle with a count of 10 → count=6. Flush asserted with disp_valid → count=0, iq_empty=1, all req vectors 0, no entry written.
- wk_prs1_rdy=16'hFFFF with the queue empty → no entry becomes valid or ready; req vectors stay 0.
